// File: rtl/seg_pkg.sv
// Shared glyph table, digit-select encoding and converter state type for the
// multiplexed 7-segment scanner.
package seg_pkg;

  // Active-low segments, bit7 = dp, bits6..0 = g..a.
  localparam logic [7:0] GLYPH_DIGIT [10] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8, 8'h80, 8'h90
  };
  localparam logic [7:0] GLYPH_BLANK = 8'hff;
  localparam logic [7:0] GLYPH_DASH  = 8'hbf;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // Active-low one-hot select for digit idx, up to 8 digits.
  function automatic logic [7:0] sel_code(input int unsigned idx);
    return ~(8'd1 << idx);
  endfunction

  function automatic logic [7:0] glyph_decode(input logic [3:0] d);
    return (d <= 4'd9) ? GLYPH_DIGIT[d] : GLYPH_BLANK;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < int'(n); i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; publishes BCD digits and overflow flag
// to a display register only once a conversion has fully completed.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DAT_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DAT_W-1:0]      dat_in,
  input  logic                  load,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  disp_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DAT_W);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  // load/busy: a load pulse is accepted only while busy is low; busy rises on
  // the accepting edge and falls when the display register has been updated.
  conv_state_e          state;
  logic [DAT_W-1:0]     bin_sr;
  logic [BCD_W-1:0]     bcd_sr;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ovf_pend;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CONV_IDLE;
      busy     <= 1'b0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (load) begin
            bin_sr   <= dat_in;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            ovf_pend <= (64'(dat_in) > MAX_VAL);
            busy     <= 1'b1;
            state    <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          // Overflowed high BCD bits fall off the top; ovf covers that case.
          bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[DAT_W-1]};
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DAT_W - 1)) state <= CONV_DONE;
        end
        CONV_DONE: begin
          disp_bcd <= bcd_sr;
          disp_ovf <= ovf_pend;
          busy     <= 1'b0;
          state    <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_n.sv
// Multiplexed common-anode display driver: scans DIGITS digits and applies
// decimal points, leading-zero blanking, per-digit blink and overflow dashes.
module seg_scan_n
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int DAT_W    = 14,
  parameter int BLINK_HZ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DAT_W-1:0]  dat_in,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] blink_en,
  output logic              busy,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] sel
);

  localparam int DIV    = CLK_HZ / SCAN_HZ;
  localparam int BDIV   = CLK_HZ / (2 * BLINK_HZ);
  localparam int TICK_W = $clog2(DIV);
  localparam int BLK_W  = $clog2(BDIV);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam logic [7:0]        SEL_RST_FULL = sel_code(0);
  localparam logic [DIGITS-1:0] SEL_RST      = SEL_RST_FULL[DIGITS-1:0];

  logic [4*DIGITS-1:0] disp_bcd;
  logic                disp_ovf;
  logic [TICK_W-1:0]   tick;
  logic [BLK_W-1:0]    blk_cnt;
  logic                blink_phase;
  logic [IDX_W-1:0]    dig_idx;
  logic [IDX_W-1:0]    idx_next;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   lead_zero;
  logic                lz_run;
  logic                blanked;
  logic [7:0]          seg_next;

  bin2bcd_seq #(
    .DAT_W  (DAT_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .dat_in   (dat_in),
    .load     (load),
    .busy     (busy),
    .disp_bcd (disp_bcd),
    .disp_ovf (disp_ovf)
  );

  assign idx_next = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);

  // Digit 0 is the most significant nibble; lead_zero[k] means digits 0..k are all zero.
  always_comb begin
    lz_run = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      nib[k]       = disp_bcd[4*(DIGITS-1-k) +: 4];
      lz_run       = lz_run & (nib[k] == 4'd0);
      lead_zero[k] = lz_run;
    end
  end

  always_comb begin
    blanked = !disp_ovf && blank_lz && lead_zero[dig_idx] &&
              (dig_idx != IDX_W'(DIGITS - 1));
    if (disp_ovf)     seg_next = GLYPH_DASH;
    else if (blanked) seg_next = GLYPH_BLANK;
    else              seg_next = glyph_decode(nib[dig_idx]);
    if (dp_in[dig_idx] && !blanked) seg_next[7] = 1'b0;
    if (blink_en[dig_idx] && blink_phase) seg_next = GLYPH_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick        <= '0;
      dig_idx     <= '0;
      sel         <= SEL_RST;
      seg_out     <= GLYPH_BLANK;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else begin
      seg_out <= seg_next;
      if (tick == TICK_W'(DIV - 1)) begin
        tick    <= '0;
        dig_idx <= idx_next;
        sel     <= {sel[DIGITS-2:0], sel[DIGITS-1]};
      end else begin
        tick <= tick + TICK_W'(1);
      end
      if (blk_cnt == BLK_W'(BDIV - 1)) begin
        blk_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// Directed bench for seg_scan_n with DIV=10, BDIV=20, four digits, 14-bit input.
module tb_seg_scan_n;

  localparam int DIGITS = 4;
  localparam int DAT_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DAT_W-1:0]  dat_in = '0;
  logic              load = 1'b0;
  logic [DIGITS-1:0] dp_in = '0;
  logic              blank_lz = 1'b0;
  logic [DIGITS-1:0] blink_en = '0;
  logic              busy;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] sel;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc;

  always #5 clk = ~clk;

  seg_scan_n #(
    .CLK_HZ   (1000),
    .SCAN_HZ  (100),
    .DIGITS   (DIGITS),
    .DAT_W    (DAT_W),
    .BLINK_HZ (25)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dat_in   (dat_in),
    .load     (load),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .seg_out  (seg_out),
    .sel      (sel)
  );

  // Edges since reset release; scan and blink positions are derived from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DAT_W-1:0] v, output int nb);
    @(negedge clk);
    dat_in = v;
    load   = 1'b1;
    step();
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      step();
    end
  endtask

  // Waits for sel to switch to digit k, then one more cycle for seg_out to follow.
  task automatic goto_digit(input int k, output bit ok);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << k);
    n = 0;
    while (sel === tgt && n < 60) begin step(); n++; end
    while (sel !== tgt && n < 60) begin step(); n++; end
    ok = (n < 60);
    step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_sel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sel !== 4'b1110) begin n_fail++; $display("FAIL reset_sel: got %b want 1110", sel); end
    n_checks++;
    if (seg_out !== 8'hff) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (seg_out !== 8'hc0) begin n_fail++; $display("FAIL reset_first_seg: got %h want c0", seg_out); end
    for (int i = 0; i < 45; i++) begin
      step();
      exp_sel = ~(4'b0001 << ((tb_cyc / 10) % 4));
      n_checks++;
      if (sel !== exp_sel) begin
        n_fail++;
        $display("FAIL scan_sel cyc=%0d: got %b want %b", tb_cyc, sel, exp_sel);
      end
    end
  endtask

  task automatic test_convert();
    int nb;
    bit ok;
    logic [7:0] e [4];
    blank_lz = 1'b0;
    do_load(14'd1234, nb);
    n_checks++;
    if (nb !== 15) begin n_fail++; $display("FAIL busy_len_1234: got %0d want 15", nb); end
    e = '{8'hf9, 8'ha4, 8'hb0, 8'h99};
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== e[k]) begin
        n_fail++;
        $display("FAIL digit_1234[%0d]: got %h want %h (sel found=%0b)", k, seg_out, e[k], ok);
      end
    end
  endtask

  task automatic test_blanking();
    int nb;
    bit ok;
    logic [7:0] e [4];
    blank_lz = 1'b1;
    dp_in    = 4'b0000;
    do_load(14'd7, nb);
    e = '{8'hff, 8'hff, 8'hff, 8'hf8};
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== e[k]) begin
        n_fail++;
        $display("FAIL blank_lz_7[%0d]: got %h want %h", k, seg_out, e[k]);
      end
    end
    dp_in = 4'b1000;
    goto_digit(3, ok);
    n_checks++;
    if (!ok || seg_out !== 8'h78) begin n_fail++; $display("FAIL dp_digit3: got %h want 78", seg_out); end
    dp_in = 4'b0001;
    goto_digit(0, ok);
    n_checks++;
    if (!ok || seg_out !== 8'hff) begin n_fail++; $display("FAIL dp_on_blanked: got %h want ff", seg_out); end
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    e = '{8'hc0, 8'hc0, 8'hc0, 8'hf8};
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== e[k]) begin
        n_fail++;
        $display("FAIL no_blank_7[%0d]: got %h want %h", k, seg_out, e[k]);
      end
    end
  endtask

  task automatic test_overflow();
    int nb;
    bit ok;
    do_load(14'd12000, nb);
    n_checks++;
    if (dut.u_conv.disp_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_12000: got %b want 1", dut.u_conv.disp_ovf); end
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== 8'hbf) begin
        n_fail++;
        $display("FAIL dash_12000[%0d]: got %h want bf", k, seg_out);
      end
    end
    dp_in = 4'b0100;
    goto_digit(2, ok);
    n_checks++;
    if (!ok || seg_out !== 8'h3f) begin n_fail++; $display("FAIL dash_dp: got %h want 3f", seg_out); end
    dp_in = 4'b0000;
    do_load(14'd9999, nb);
    n_checks++;
    if (dut.u_conv.disp_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_9999: got %b want 0", dut.u_conv.disp_ovf); end
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== 8'h90) begin
        n_fail++;
        $display("FAIL digit_9999[%0d]: got %h want 90", k, seg_out);
      end
    end
    do_load(14'd10000, nb);
    goto_digit(3, ok);
    n_checks++;
    if (!ok || seg_out !== 8'hbf) begin n_fail++; $display("FAIL dash_10000: got %h want bf", seg_out); end
  endtask

  task automatic test_ignored_load();
    int nb;
    bit ok;
    logic [7:0] e [4];
    @(negedge clk);
    dat_in = 14'd4321;
    load   = 1'b1;
    step();
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      load = (nb == 5);
      if (nb == 5) dat_in = 14'd99;
      step();
    end
    load = 1'b0;
    n_checks++;
    if (nb !== 15) begin n_fail++; $display("FAIL busy_len_ignored: got %0d want 15", nb); end
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL no_requeue: got busy=%b want 0", busy); end
    e = '{8'h99, 8'hb0, 8'ha4, 8'hf9};
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== e[k]) begin
        n_fail++;
        $display("FAIL digit_4321[%0d]: got %h want %h", k, seg_out, e[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int busy_seen;
    blank_lz = 1'b0;
    @(negedge clk);
    dat_in = 14'd5678;
    load   = 1'b1;
    step();
    load = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_checks++;
    if (sel !== 4'b1110 || seg_out !== 8'hff) begin
      n_fail++;
      $display("FAIL mid_reset_out: got sel=%b seg=%h want sel=1110 seg=ff", sel, seg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0) begin n_fail++; $display("FAIL mid_reset_resume: got %0d busy cycles want 0", busy_seen); end
    for (int k = 0; k < 4; k++) begin
      goto_digit(k, ok);
      n_checks++;
      if (!ok || seg_out !== 8'hc0) begin
        n_fail++;
        $display("FAIL mid_reset_zero[%0d]: got %h want c0", k, seg_out);
      end
    end
    blank_lz = 1'b1;
    goto_digit(0, ok);
    n_checks++;
    if (!ok || seg_out !== 8'hff) begin n_fail++; $display("FAIL zero_blank_d0: got %h want ff", seg_out); end
    goto_digit(3, ok);
    n_checks++;
    if (!ok || seg_out !== 8'hc0) begin n_fail++; $display("FAIL zero_blank_d3: got %h want c0", seg_out); end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    int nb;
    int idx;
    int ph;
    logic [7:0] g [4];
    logic [7:0] exp_seg;
    blank_lz = 1'b0;
    blink_en = 4'b0110;
    g = '{8'h92, 8'h82, 8'hf8, 8'h80};
    do_load(14'd5678, nb);
    for (int i = 0; i < 80; i++) begin
      step();
      idx = ((tb_cyc - 1) / 10) % 4;
      ph  = ((tb_cyc - 1) / 20) % 2;
      exp_seg = (blink_en[idx] && ph == 1) ? 8'hff : g[idx];
      n_checks++;
      if (seg_out !== exp_seg) begin
        n_fail++;
        $display("FAIL blink cyc=%0d digit=%0d: got %h want %h", tb_cyc, idx, seg_out, exp_seg);
      end
    end
    blink_en = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_ignored_load();
    test_reset_mid();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
